// File: rtl/led_status_arbiter.sv
// led_status_arbiter: chooses the board LED pattern among heartbeat, HPS pattern, done flash and latched fault.
module led_status_arbiter #(
  parameter int TICK_DIV    = 5000000,
  parameter int HOLD_TICKS  = 20,
  parameter int FLASH_TICKS = 6
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] hps_leds,
  input  logic       ann_busy,
  input  logic       ann_done,
  input  logic       ann_err,
  input  logic [7:0] err_code,
  input  logic       err_clr,
  output logic [7:0] leds_out,
  output logic [1:0] state_o
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {HEARTBEAT = 2'd0, HPS = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic tick, hb, hb_nxt, hps_chg;
  logic [7:0] hps_prev, hold_cnt, hold_nxt, flash_cnt, flash_nxt, code, code_nxt, leds_nxt, hb_leds;
  assign tick    = cnt == CW'(TICK_DIV - 1);
  assign hb_nxt  = hb ^ tick;
  assign hps_chg = hps_leds != hps_prev;
  assign hb_leds = {ann_busy, 6'b0, hb_nxt};
  assign state_o = state;
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt       <= '0;
      hb        <= 1'b0;
      hps_prev  <= 8'h00;
      state     <= HEARTBEAT;
      hold_cnt  <= 8'h00;
      flash_cnt <= 8'h00;
      code      <= 8'h00;
      leds_out  <= 8'h00;
    end else begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      hb        <= hb_nxt;
      hps_prev  <= hps_leds;
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      flash_cnt <= flash_nxt;
      code      <= code_nxt;
      leds_out  <= leds_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    flash_nxt = flash_cnt;
    code_nxt  = code;
    leds_nxt  = leds_out;
    case (state)
      HEARTBEAT, HPS: begin
        if (ann_err) begin
          state_nxt = ERROR;
          code_nxt  = err_code;
          leds_nxt  = err_code;
        end else if (ann_done) begin
          state_nxt = DONE;
          flash_nxt = 8'(FLASH_TICKS);
          leds_nxt  = 8'hFF;
        end else if (hps_chg) begin
          state_nxt = HPS;
          hold_nxt  = 8'(HOLD_TICKS);
          leds_nxt  = hps_leds;
        end else if (state == HPS && tick && hold_cnt <= 8'd1) begin
          state_nxt = HEARTBEAT;
          hold_nxt  = 8'h00;
          leds_nxt  = hb_leds;
        end else if (state == HPS) begin
          hold_nxt  = tick ? hold_cnt - 8'd1 : hold_cnt;
          leds_nxt  = hps_leds;
        end else begin
          leds_nxt  = hb_leds;
        end
      end
      DONE: begin
        if (ann_err) begin
          state_nxt = ERROR;
          code_nxt  = err_code;
          leds_nxt  = err_code;
        end else if (ann_done) begin
          flash_nxt = 8'(FLASH_TICKS);
          leds_nxt  = 8'hFF;
        end else if (tick && flash_cnt <= 8'd1) begin
          state_nxt = HEARTBEAT;
          flash_nxt = 8'h00;
          leds_nxt  = hb_leds;
        end else if (tick) begin
          flash_nxt = flash_cnt - 8'd1;
          leds_nxt  = ~leds_out;
        end
      end
      ERROR: begin
        // a fresh fault arriving with the acknowledge replaces the latched one
        if (err_clr && ann_err) begin
          code_nxt  = err_code;
          leds_nxt  = err_code;
        end else if (err_clr) begin
          state_nxt = HEARTBEAT;
          leds_nxt  = hb_leds;
        end
      end
      default: state_nxt = HEARTBEAT;
    endcase
  end
endmodule
